// File: rtl/uart_pkg.sv
// Shared UART definitions: default line parameters, FSM state codes and a
// width helper for the bit-timing counters (used by both RX and TX sides).
package uart_pkg;

  localparam int unsigned DEFAULT_SYSTEM_SPEED = 12000000;
  localparam int unsigned DEFAULT_BAUDRATE     = 115200;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Number of bits needed to hold max_val (at least 1).
  function automatic int unsigned timer_width(input int unsigned max_val);
    for (int unsigned i = 1; i < 32; i++) begin
      if ((max_val >> i) == 0) return i;
    end
    return 32;
  endfunction

endpackage

// File: rtl/rs232_receiver_bit_timer.sv
// Loadable down-counter: counts to zero after a load and then holds there
// until reloaded; tc is high while the count is zero.
module bit_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Load takes priority; otherwise count down and stop at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/rs232_receiver.sv
// 8N1 serial receiver: synchronizes rx, finds the start-bit centre, samples
// eight data bits LSB first, checks the stop bit and hands the byte to the
// consumer with valid/ack, tracking frame and overrun errors.
module rs232_receiver
  import uart_pkg::*;
#(
  parameter int unsigned SYSTEM_SPEED = DEFAULT_SYSTEM_SPEED,
  parameter int unsigned BAUDRATE     = DEFAULT_BAUDRATE
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx,
  input  logic       ack_i,
  output logic [7:0] dat_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy
);

  localparam int unsigned BIT_TICKS  = SYSTEM_SPEED / BAUDRATE;
  localparam int unsigned HALF_TICKS = BIT_TICKS / 2;
  localparam int unsigned TW         = timer_width(BIT_TICKS - 1);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(HALF_TICKS - 1);

  logic          sync1, sync2;
  logic          rx_s;
  logic [1:0]    state;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          tc;

  // Two-flop synchronizer, idle-high on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  assign rx_s = sync2;

  // Timer reload: half a bit to reach the start-bit centre, then whole bits.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = BIT_LOAD;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          timer_load = 1'b1;
          timer_val  = HALF_LOAD;
        end
      end
      ST_START: timer_load = tc && !rx_s;
      ST_DATA:  timer_load = tc;
      default:  timer_load = 1'b0;
    endcase
  end

  bit_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (tc)
  );

  // Frame sequencing and bit capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          if (tc) begin
            bit_idx <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (tc) begin
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end
        end
        default: begin
          if (tc) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Consumer handshake; a byte landing in the ack cycle beats the ack, and
  // a bad stop bit sets frame_err even if ack clears the flags that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_o       <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (ack_i) begin
        valid_o     <= 1'b0;
        frame_err_o <= 1'b0;
        overrun_o   <= 1'b0;
      end
      if (state == ST_STOP && tc) begin
        if (rx_s) begin
          dat_o   <= shift;
          valid_o <= 1'b1;
          if (valid_o && !ack_i) overrun_o <= 1'b1;
        end else begin
          frame_err_o <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_rs232_receiver.sv
// Self-checking bench for rs232_receiver at default rates (104 clocks/bit).
module tb_rs232_receiver;

  localparam int BIT  = 12000000 / 115200;
  localparam int HALF = BIT / 2;
  // Edge (counted from the edge after which rx falls) at which the stop bit
  // is sampled: 2 synchronizer edges, 1 idle-detect edge, half a bit to the
  // start centre, then nine whole bits.
  localparam int STOP_EDGE = 3 + HALF + 9 * BIT;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       rx    = 1'b1;
  logic       ack_i = 1'b0;
  logic [7:0] dat_o;
  logic       valid_o, frame_err_o, overrun_o, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the consumer-visible state.
  logic [7:0] m_dat   = '0;
  logic       m_valid = 1'b0;
  logic       m_fe    = 1'b0;
  logic       m_ov    = 1'b0;

  rs232_receiver #(.SYSTEM_SPEED(12000000), .BAUDRATE(115200)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx          (rx),
    .ack_i       (ack_i),
    .dat_o       (dat_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy        (busy)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [11:0] obs();
    return {dat_o, valid_o, frame_err_o, overrun_o, busy};
  endfunction

  function automatic logic [11:0] expv(input logic b);
    return {m_dat, m_valid, m_fe, m_ov, b};
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Model effect of a complete frame (ack_same: ack held in the load cycle).
  task automatic model_frame(input logic [7:0] d, input logic stop, input logic ack_same);
    logic vb;
    vb = m_valid;
    if (ack_same) begin
      m_valid = 1'b0;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
    end
    if (stop) begin
      m_dat   = d;
      m_valid = 1'b1;
      if (vb && !ack_same) m_ov = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
  endtask

  // Drive one full 10-bit frame; caller is at #1 after a clock edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_at_load);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10 * BIT; i++) begin
      rx = bits[i / BIT];
      tick(1);
      if (ack_at_load && (i + 1) == STOP_EDGE - 1) ack_i = 1'b1;
      if ((i + 1) == STOP_EDGE) ack_i = 1'b0;
    end
    rx = 1'b1;
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    tick(1);
    ack_i = 1'b0;
    m_valid = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
    n_checks++;
    if (obs() !== expv(1'b0)) begin
      n_fail++;
      $display("FAIL ack_clear: got %h expected %h", obs(), expv(1'b0));
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(3);
    n_checks++;
    if (obs() !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs(), 12'h000);
    end
    rst_i = 1'b0;
    tick(5);
  endtask

  // 0x55 with a cycle-exact check of the valid rise.
  task automatic test_basic();
    logic [9:0] bits;
    bits = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10 * BIT; i++) begin
      rx = bits[i / BIT];
      tick(1);
      if ((i + 1) == STOP_EDGE - 1) begin
        n_checks++;
        if (valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_pre_latency: valid got %b expected 0", valid_o);
        end
      end
      if ((i + 1) == STOP_EDGE) begin
        n_checks++;
        if ({dat_o, valid_o, frame_err_o, overrun_o} !== {8'h55, 3'b100}) begin
          n_fail++;
          $display("FAIL basic_latency: got %h/%b%b%b expected 55/100",
                   dat_o, valid_o, frame_err_o, overrun_o);
        end
      end
    end
    rx = 1'b1;
    model_frame(8'h55, 1'b1, 1'b0);
    tick(4);
    n_checks++;
    if (obs() !== expv(1'b0)) begin
      n_fail++;
      $display("FAIL basic_done: got %h expected %h", obs(), expv(1'b0));
    end
    do_ack();
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    tick(10);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy: got %b expected 1", busy);
    end
    tick(20);
    rx = 1'b1;
    tick(100);
    n_checks++;
    if (obs() !== expv(1'b0)) begin
      n_fail++;
      $display("FAIL glitch_idle: got %h expected %h", obs(), expv(1'b0));
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'hA3, 1'b0, 1'b0);
    model_frame(8'hA3, 1'b0, 1'b0);
    tick(4);
    n_checks++;
    if (obs() !== expv(1'b0)) begin
      n_fail++;
      $display("FAIL frame_err: got %h expected %h", obs(), expv(1'b0));
    end
    do_ack();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 1'b0);
    model_frame(8'h11, 1'b1, 1'b0);
    tick(3);
    send_frame(8'h22, 1'b1, 1'b0);
    model_frame(8'h22, 1'b1, 1'b0);
    tick(3);
    n_checks++;
    if (obs() !== expv(1'b0)) begin
      n_fail++;
      $display("FAIL overrun: got %h expected %h", obs(), expv(1'b0));
    end
    do_ack();
  endtask

  task automatic test_ack_race();
    send_frame(8'h11, 1'b1, 1'b0);
    model_frame(8'h11, 1'b1, 1'b0);
    tick(3);
    send_frame(8'h7E, 1'b1, 1'b1);
    model_frame(8'h7E, 1'b1, 1'b1);
    tick(3);
    n_checks++;
    if (obs() !== expv(1'b0)) begin
      n_fail++;
      $display("FAIL ack_race: got %h expected %h", obs(), expv(1'b0));
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    send_frame(a, 1'b1, 1'b0);
    model_frame(a, 1'b1, 1'b0);
    send_frame(b, 1'b1, 1'b0);
    model_frame(b, 1'b1, 1'b0);
    tick(3);
    n_checks++;
    if (obs() !== expv(1'b0)) begin
      n_fail++;
      $display("FAIL back_to_back: got %h expected %h", obs(), expv(1'b0));
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] bits;
    bits = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 5 * BIT + HALF; i++) begin
      rx = bits[i / BIT];
      tick(1);
    end
    #2;
    rst_i = 1'b1;
    #1;
    m_dat = '0; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    n_checks++;
    if (obs() !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", obs(), 12'h000);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int i = 5 * BIT + HALF + 1; i < 10 * BIT; i++) begin
      rx = bits[i / BIT];
      tick(1);
    end
    rx = 1'b1;
    tick(20);
    n_checks++;
    if (obs() !== expv(1'b0)) begin
      n_fail++;
      $display("FAIL reset_remainder: got %h expected %h", obs(), expv(1'b0));
    end
    send_frame(8'h3C, 1'b1, 1'b0);
    model_frame(8'h3C, 1'b1, 1'b0);
    tick(3);
    n_checks++;
    if (obs() !== expv(1'b0)) begin
      n_fail++;
      $display("FAIL after_reset_frame: got %h expected %h", obs(), expv(1'b0));
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop, ack_ld;
    for (int k = 0; k < 8; k++) begin
      d      = 8'($urandom);
      stop   = ($urandom_range(0, 3) != 0);
      ack_ld = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) do_ack();
      send_frame(d, stop, ack_ld);
      model_frame(d, stop, ack_ld);
      tick($urandom_range(2, 20));
      n_checks++;
      if (obs() !== expv(1'b0)) begin
        n_fail++;
        $display("FAIL random_%0d: got %h expected %h", k, obs(), expv(1'b0));
      end
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_ack_race();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs232_receiver.md
RS232_RECEIVER -- requirements
Module: rs232_receiver

Interface
REQ-001 SHALL have parameter SYSTEM_SPEED, default 12000000, clk_i frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115200, line rate in bps.
REQ-003 SHALL have port clk_i  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port ack_i  input  1  consumer has taken dat_o this cycle.
REQ-007 SHALL have port dat_o  output  8  last received byte.
REQ-008 SHALL have port valid_o  output  1  dat_o holds an unconsumed byte.
REQ-009 SHALL have port frame_err_o  output  1  sticky flag: a stop bit was sampled low.
REQ-010 SHALL have port overrun_o  output  1  sticky flag: an unconsumed byte was overwritten.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1.
REQ-013 SHALL use BIT_TICKS = SYSTEM_SPEED/BAUDRATE (integer division, 104 at default) and HALF_TICKS = BIT_TICKS/2 (52).
REQ-014 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-015 IDLE: a synchronized rx of 0 SHALL move the FSM to START and load the tick counter.
REQ-016 START: after HALF_TICKS cycles, rx=0 SHALL move the FSM to DATA; rx=1 is a glitch and SHALL return the FSM to IDLE with no flag change.
REQ-017 DATA: the FSM SHALL sample every BIT_TICKS cycles into shift register bit n (n=0..7, LSB first), then enter STOP.
REQ-018 STOP: after BIT_TICKS cycles, rx=1 SHALL load dat_o and set valid_o on the next edge; rx=0 SHALL discard the byte, set frame_err_o and leave dat_o and valid_o unchanged; either way the FSM returns to IDLE.
REQ-019 Latency SHALL be 1 cycle from the stop-bit sample to valid_o high.
REQ-020 The tick counter SHALL be wide enough for BIT_TICKS-1 and SHALL wrap to reload, never free-run.
REQ-021 ack_i with valid_o=1 SHALL clear valid_o, frame_err_o and overrun_o on the next edge; ack_i with valid_o=0 SHALL only clear the flags.
REQ-022 A new byte arriving with valid_o=1 and no ack_i in the same cycle SHALL overwrite dat_o, keep valid_o=1 and set overrun_o.
REQ-023 A new byte arriving in the same cycle as ack_i SHALL win: dat_o updated, valid_o=1, no overrun.
REQ-024 A back-to-back start bit immediately after the stop sample SHALL be accepted (no dead cycles beyond IDLE entry).

Reset
REQ-025 rst_i high SHALL immediately force IDLE, counters 0, dat_o=8'h00, valid_o=0, frame_err_o=0, overrun_o=0, busy=0, and synchronizer flops=1.
REQ-026 Reset mid-frame SHALL abandon the frame, and the remainder SHALL NOT produce valid_o (a later low bit may start a new frame).

Structure
REQ-027 FSM state encodings and default SYSTEM_SPEED/BAUDRATE SHALL live in shared package uart_pkg, reused by the transmit side.
REQ-028 One sub-module bit_timer (loadable down-counter, terminal-count pulse, parameterized width) SHALL be instantiated; everything else is inline.
REQ-029 Implementation SHALL be 120-400 lines of RTL, with no vendor primitives.

Verification
REQ-030 Send 0x55 at 115200 with default parameters -> dat_o=0x55, valid_o=1 one cycle after the stop-bit sample, flags 0.
REQ-031 Pulse rx low for 30 cycles from idle -> FSM back to IDLE, valid_o stays 0, no flags set.
REQ-032 Send 0xA3 with the stop bit forced low -> frame_err_o=1, valid_o=0, dat_o unchanged.
REQ-033 Send 0x11 then 0x22 with no ack_i -> dat_o=0x22, valid_o=1, overrun_o=1; ack_i -> all three cleared next cycle.
REQ-034 Send 0x7E with ack_i asserted exactly in the load cycle while holding 0x11 -> dat_o=0x7E, valid_o=1, overrun_o=0.
REQ-035 Assert rst_i during bit 4 of 0xF0 -> outputs zero immediately; next clean frame 0x3C -> received correctly.
